// File: rtl/jtframe_dwnld_prog.sv
// rtl/jtframe_dwnld_prog.sv - ioctl byte stream to paced SDRAM prog_* writes through a small FIFO
// Optional additive checksum of accepted bytes under `JTFRAME_DWNLD_CHKSUM_EN.
module jtframe_dwnld_prog #(
  parameter int WE_CYCLES  = 8,
  parameter int GAP_CYCLES = 2,
  parameter int FIFO_AW    = 2
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic [21:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic        prog_we,
  output logic        dwnld_busy,
  output logic        overflow,
  output logic [15:0] chksum
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [3:0] WE_LOAD  = 4'(WE_CYCLES - 1);
  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
  localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

  // Entry layout: {byte address[21:0], data[7:0]}
  logic [29:0]        mem_q [DEPTH];
  logic [FIFO_AW:0]   wptr_q, rptr_q;
  logic [1:0]         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [21:0]        addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic [1:0]         mask_q, mask_d;
  logic               we_q, we_d;
  logic               ovf_q, ovf_d;
  logic               dl_q;
  logic               empty, full, pop, push, accept, rise;
  logic [29:0]        rd_entry;

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                    (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign pop      = (state_q == ST_IDLE) && !empty;
  assign push     = downloading && ioctl_wr;
  // A pop in the same cycle frees the slot a full FIFO needs
  assign accept   = push && (!full || pop);
  assign rise     = downloading && !dl_q;
  assign rd_entry = mem_q[rptr_q[FIFO_AW-1:0]];

  always_ff @(posedge clk_sys) begin
    if (accept) mem_q[wptr_q[FIFO_AW-1:0]] <= {ioctl_addr, ioctl_data};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    we_d    = we_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          addr_d  = {1'b0, rd_entry[29:9]};
          data_d  = rd_entry[7:0];
          mask_d  = rd_entry[8] ? 2'b01 : 2'b10;
          we_d    = 1'b1;
          cnt_d   = WE_LOAD;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (cnt_q == 4'd0) begin
          we_d = 1'b0;
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = GAP_LOAD;
            state_d = ST_GAP;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 4'd0) state_d = ST_IDLE;
        else cnt_d = cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ovf_d = rise ? 1'b0 : ovf_q;
    if (push && !accept) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 22'd0;
      data_q  <= 8'd0;
      mask_q  <= 2'b00;
      we_q    <= 1'b0;
      ovf_q   <= 1'b0;
      dl_q    <= 1'b0;
    end else begin
      if (accept) wptr_q <= wptr_q + PTR_ONE;
      if (pop) rptr_q <= rptr_q + PTR_ONE;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      we_q    <= we_d;
      ovf_q   <= ovf_d;
      dl_q    <= downloading;
    end
  end

`ifdef JTFRAME_DWNLD_CHKSUM_EN
  logic [15:0] chk_q, chk_d;

  always_comb begin
    chk_d = rise ? 16'd0 : chk_q;
    if (accept) chk_d = chk_d + {8'd0, ioctl_data};
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) chk_q <= 16'd0;
    else chk_q <= chk_d;
  end

  assign chksum = chk_q;
`else
  assign chksum = 16'h0000;
`endif

  assign prog_addr  = addr_q;
  assign prog_data  = data_q;
  assign prog_mask  = mask_q;
  assign prog_we    = we_q;
  assign overflow   = ovf_q;
  assign dwnld_busy = downloading || !empty || (state_q != ST_IDLE);

endmodule
